// File: rtl/fifo_sync_prog_if.sv
// rtl/fifo_sync_prog_if.sv - write/read/flag bundle for fifo_sync_prog
interface fifo_sync_prog_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [CW-1:0]    af_thresh;
    logic [CW-1:0]    ae_thresh;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh,
        input  rd_data, full, empty, count, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh,
        output rd_data, full, empty, count, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_prog.sv
// rtl/fifo_sync_prog.sv - single-clock FWFT FIFO, any DEPTH, programmable thresholds
module fifo_sync_prog #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    fifo_sync_prog_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_wr_store;

    assign w_full   = (r_count == DEPTH_C);
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = bus.rd_en & ~w_empty;
    // A read from a full FIFO frees the slot the simultaneous write lands in.
    assign w_wr_acc = bus.wr_en & (~w_full | bus.rd_en);
    assign w_wr_store = w_wr_acc & ~bus.flush & ~rst;

    // Storage has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_wr_store) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
            if (bus.wr_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.rd_data      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.count        = r_count;
    assign bus.almost_full  = (r_count >= bus.af_thresh);
    assign bus.almost_empty = (r_count <= bus.ae_thresh);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb/tb_fifo_sync_prog.sv - self-checking bench for fifo_sync_prog against a queue model
module tb_fifo_sync_prog;
    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_sync_prog_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_sync_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] q[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    // Applies one cycle of stimulus and advances the queue model by the FIFO's rules.
    task automatic step(input bit wr, input logic [WIDTH-1:0] d, input bit rd,
                        input bit fl = 1'b0, input bit rs = 1'b0);
        bit was_empty;
        bit was_full;
        logic [WIDTH-1:0] popped;
        bus.wr_en = wr; bus.wr_data = d; bus.rd_en = rd; bus.flush = fl; rst = rs;
        if (rs || fl) begin
            q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            was_empty = (q.size() == 0);
            was_full  = (q.size() == DEPTH);
            if (rd && was_empty) m_unf = 1'b1;
            if (wr && was_full && !rd) m_ovf = 1'b1;
            if (rd && !was_empty) popped = q.pop_front();
            if (wr && !(was_full && !rd)) q.push_back(d);
        end
        @(posedge clk); #1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.af_thresh = CW'(3); bus.ae_thresh = CW'(1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
        checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {bus.overflow, bus.underflow}); end
        checks++; if ({bus.almost_empty, bus.almost_full} !== 2'b10) begin errors++; $display("FAIL reset_almost got=%b exp=10", {bus.almost_empty, bus.almost_full}); end
        bus.af_thresh = CW'(0); #1;
        checks++; if (bus.almost_full !== 1'b1) begin errors++; $display("FAIL reset_af_zero got=%b exp=1", bus.almost_full); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
            checks++; if (bus.count !== CW'(i + 1)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", bus.count, i + 1); end
        end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", bus.full); end
        checks++; if (bus.rd_data !== 8'h11) begin errors++; $display("FAIL fill_head got=%h exp=11", bus.rd_data); end
        step(1'b1, 8'h66, 1'b0);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
        checks++; if (bus.count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", bus.count, DEPTH); end
        checks++; if (bus.rd_data !== 8'h11) begin errors++; $display("FAIL ovf_head got=%h exp=11", bus.rd_data); end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (bus.rd_data !== 8'(8'h11 * (i + 1))) begin errors++; $display("FAIL drain_data got=%h exp=%h", bus.rd_data, 8'(8'h11 * (i + 1))); end
            step(1'b0, '0, 1'b1);
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL drain_rd_zero got=%h exp=00", bus.rd_data); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL drain_no_unf got=%b exp=0", bus.underflow); end
        step(1'b0, '0, 1'b1);
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got=%b exp=1", bus.underflow); end
        checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL unf_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
        checks++; if (bus.count !== CW'(DEPTH)) begin errors++; $display("FAIL wrap_count_full got=%0d exp=%0d", bus.count, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (bus.rd_data !== 8'(8'hA0 + i)) begin errors++; $display("FAIL wrap_data got=%h exp=%h", bus.rd_data, 8'(8'hA0 + i)); end
            step(1'b0, '0, 1'b1);
        end
        checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL wrap_count_end got=%0d exp=0", bus.count); end
    endtask

    task automatic test_full_rw();
        logic [WIDTH-1:0] exp_seq [DEPTH];
        exp_seq = '{8'h55, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.rd_data !== 8'(8'h11 * (i + 1))) begin errors++; $display("FAIL frw_head got=%h exp=%h", bus.rd_data, 8'(8'h11 * (i + 1))); end
            step(1'b1, 8'(8'hB0 + i), 1'b1);
            checks++; if (bus.count !== CW'(DEPTH)) begin errors++; $display("FAIL frw_count got=%0d exp=%0d", bus.count, DEPTH); end
            checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL frw_ovf got=%b exp=0", bus.overflow); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (bus.rd_data !== exp_seq[i]) begin errors++; $display("FAIL frw_readout got=%h exp=%h", bus.rd_data, exp_seq[i]); end
            step(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_thresholds();
        step(1'b0, '0, 1'b0, 1'b1);
        bus.af_thresh = CW'(4); bus.ae_thresh = CW'(1); #1;
        for (int c = 0; c <= 4; c++) begin
            checks++; if (bus.almost_empty !== (c <= 1)) begin errors++; $display("FAIL thr_ae count=%0d got=%b exp=%b", c, bus.almost_empty, c <= 1); end
            checks++; if (bus.almost_full !== (c >= 4)) begin errors++; $display("FAIL thr_af count=%0d got=%b exp=%b", c, bus.almost_full, c >= 4); end
            if (c < 4) step(1'b1, 8'($urandom), 1'b0);
        end
        bus.af_thresh = CW'(5); #1;
        checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL thr_af_change got=%b exp=0", bus.almost_full); end
        step(1'b1, 8'($urandom), 1'b0);
        checks++; if (bus.almost_full !== 1'b1) begin errors++; $display("FAIL thr_af_at5 got=%b exp=1", bus.almost_full); end
    endtask

    task automatic test_flush_rst();
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
            step(1'b0, '0, 1'b1);
            step(1'b0, '0, 1'b1);
            checks++; if ({bus.count, bus.overflow} !== {CW'(3), 1'b1}) begin errors++; $display("FAIL fr_setup pass=%0d got=%0d/%b exp=3/1", pass, bus.count, bus.overflow); end
            step(1'b1, 8'h77, 1'b0, pass == 0, pass == 1);
            checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL fr_count pass=%0d got=%0d exp=0", pass, bus.count); end
            checks++; if ({bus.empty, bus.overflow} !== 2'b10) begin errors++; $display("FAIL fr_flags pass=%0d got=%b exp=10", pass, {bus.empty, bus.overflow}); end
            checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL fr_rd_data pass=%0d got=%h exp=00", pass, bus.rd_data); end
            step(1'b1, 8'h99, 1'b0);
            checks++; if ({bus.count, bus.rd_data} !== {CW'(1), 8'h99}) begin errors++; $display("FAIL fr_absent pass=%0d got=%0d/%h exp=1/99", pass, bus.count, bus.rd_data); end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] exp_data;
        for (int n = 0; n < 400; n++) begin
            bus.af_thresh = CW'($urandom_range(0, 7));
            bus.ae_thresh = CW'($urandom_range(0, 7));
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
                 $urandom_range(0, 59) == 0);
            exp_data = (q.size() != 0) ? q[0] : '0;
            checks++; if (bus.count !== CW'(q.size())) begin errors++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, bus.count, q.size()); end
            checks++; if (bus.rd_data !== exp_data) begin errors++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, bus.rd_data, exp_data); end
            checks++; if ({bus.full, bus.empty} !== {q.size() == DEPTH, q.size() == 0}) begin errors++; $display("FAIL rnd_fe n=%0d got=%b%b size=%0d", n, bus.full, bus.empty, q.size()); end
            checks++; if ({bus.almost_full, bus.almost_empty} !== {q.size() >= int'(bus.af_thresh), q.size() <= int'(bus.ae_thresh)}) begin errors++; $display("FAIL rnd_almost n=%0d got=%b%b size=%0d af=%0d ae=%0d", n, bus.almost_full, bus.almost_empty, q.size(), bus.af_thresh, bus.ae_thresh); end
            checks++; if ({bus.overflow, bus.underflow} !== {m_ovf, m_unf}) begin errors++; $display("FAIL rnd_err n=%0d got=%b%b exp=%b%b", n, bus.overflow, bus.underflow, m_ovf, m_unf); end
        end
    endtask

    initial begin
        bus.flush = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = '0;
        bus.af_thresh = '0; bus.ae_thresh = '0;
        test_reset();
        bus.af_thresh = CW'(4); bus.ae_thresh = CW'(1);
        test_fill_overflow();
        test_drain_underflow();
        test_wrap();
        test_full_rw();
        test_thresholds();
        test_flush_rst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
